alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single miniALU instance between two requesters. Each requester presents a 4-bit operand pair plus operation/sign selects over a valid/ready handshake. The block arbitrates round-robin, registers the operands into the ALU, captures the 20-bit result and returns it to the owner over a response valid/ready handshake. It sits between the front-end command sources and the ALU datapath.

## Interface
- No parameters; requester count is fixed at 2.
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  2  bit i: requester i presents a command
- req_ready  out  2  bit i: command from requester i accepted this cycle
- req_op1  in  8  [3:0] requester 0 op1, [7:4] requester 1 op1
- req_op2  in  8  [3:0] requester 0 op2, [7:4] requester 1 op2
- req_operation  in  2  bit i: requester i operation select (0 arithmetic, 1 shift)
- req_sign  in  2  bit i: requester i sign select (add/sub, left/right)
- resp_valid  out  2  bit i: resp_result belongs to requester i
- resp_ready  in  2  bit i: requester i takes the response
- resp_result  out  20  registered ALU result
- grant_id  out  1  index of the current transaction owner
- busy  out  1  high in any state other than IDLE
- done_count  out  16  number of completed responses, wraps 0xFFFF -> 0

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid is set, select a winner and assert req_ready[winner] combinationally in the same cycle. No other req_ready bit may be high. On that edge, latch the winner's op1/op2/operation/sign, set grant_id to the winner, update last_grant to the winner, and go to EXEC. If no req_valid is set, stay in IDLE.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the index != last_grant.
  - last_grant resets to 1, so requester 0 wins the first simultaneous request.
- EXEC: the latched operands drive miniALU. Its output is registered into resp_result. Go to RESP.
- RESP: assert resp_valid[grant_id]. When resp_ready[grant_id] is high, complete the transaction, increment done_count and go to IDLE. Otherwise hold resp_valid and resp_result stable.
- resp_ready of the non-owner is ignored. req_ready is 0 in EXEC and RESP.
- Arithmetic is identical to miniALU, with operands zero-extended to 20 bits:
  - {op=0, sign=0}: op1+op2 (0..30).
  - {0,1}: op1-op2 modulo 2^20 (3-5 = 0xFFFFE).
  - {1,0}: op1<<op2 (max 15<<15 = 0x78000).
  - {1,1}: logical op1>>op2.
- resp_result holds its last value in IDLE and is overwritten only in EXEC.
- A requester may drop req_valid while not granted; no state is kept for it.
- Reset (rst_n low at an edge, any state, including mid-transaction):
  - FSM goes to IDLE and any in-flight transaction is discarded with no response.
  - req_ready=0, resp_valid=0, resp_result=0, grant_id=0, busy=0, done_count=0, last_grant=1.

## Timing
- Accept edge N (the IDLE cycle with req_valid & req_ready). EXEC occupies cycle N+1, and resp_valid is high from cycle N+2.
- Response completes on the first edge at or after N+2 where resp_ready is high.
- With resp_ready tied high, a transaction takes 3 cycles; the next accept can occur in cycle N+3.
- req_ready depends combinationally on req_valid and the state. All other outputs are registered-state decodes.
- busy rises the cycle after accept and falls the cycle after the response handshake.

## Test plan
- Reset then a single request, req0 op1=3 op2=5 operation=0 sign=0 -> req_ready[0] high in the accept cycle, resp_valid[0] two cycles later with resp_result=8, done_count=1.
- Cover all four ops on req1, with resp_ready high:
  - 3-5 -> 0xFFFFE
  - 15<<15 -> 0x78000
  - 8>>3 -> 1
  - 15+15 -> 30
  - resp_valid[1] only; grant_id=1.
- Both requesters valid continuously for 4 transactions -> grant order 0,1,0,1, and req_ready is never set on both bits at once.
- Backpressure: hold resp_ready[0]=0 for 5 cycles while req1 is valid -> resp_valid[0] and resp_result stay stable, req_ready stays 0, and req1 is accepted the cycle after the response completes.
- Assert rst_n=0 for one cycle during EXEC -> next cycle all outputs are 0, no response is issued, and a following simultaneous request grants requester 0.
- Run 65536 completions -> done_count wraps to 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one miniALU
// Accept in IDLE, compute in EXEC, hold the registered result in RESP until the owner takes it.

module mini_alu (
  input  logic [3:0]  op1_i,
  input  logic [3:0]  op2_i,
  input  logic        operation_i,
  input  logic        sign_i,
  output logic [19:0] result_o
);

  logic [19:0] a;
  logic [19:0] b;

  assign a = {16'd0, op1_i};
  assign b = {16'd0, op2_i};

  always_comb begin
    result_o = 20'd0;
    case ({operation_i, sign_i})
      2'b00:   result_o = a + b;
      2'b01:   result_o = a - b;
      2'b10:   result_o = a << op2_i;
      default: result_o = a >> op2_i;
    endcase
  end

endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_op1,
  input  logic [7:0]  req_op2,
  input  logic [1:0]  req_operation,
  input  logic [1:0]  req_sign,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [19:0] resp_result,
  output logic        grant_id,
  output logic        busy,
  output logic [15:0] done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op1_q, op1_d;
  logic [3:0]  op2_q, op2_d;
  logic        operation_q, operation_d;
  logic        sign_q, sign_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [19:0] result_q, result_d;
  logic [15:0] done_count_q, done_count_d;

  logic        winner;
  logic [19:0] alu_result;

  mini_alu u_alu (
    .op1_i       (op1_q),
    .op2_i       (op2_q),
    .operation_i (operation_q),
    .sign_i      (sign_q),
    .result_o    (alu_result)
  );

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    winner = req_valid[1];
    if (req_valid == 2'b11) begin
      winner = ~last_grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    operation_d  = operation_q;
    sign_d       = sign_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    done_count_d = done_count_q;
    req_ready    = 2'b00;

    case (state_q)
      IDLE: begin
        // rst_n gates the handshake so a command is never acknowledged on a reset edge.
        if ((|req_valid) && rst_n) begin
          req_ready    = winner ? 2'b10 : 2'b01;
          op1_d        = winner ? req_op1[7:4] : req_op1[3:0];
          op2_d        = winner ? req_op2[7:4] : req_op2[3:0];
          operation_d  = req_operation[winner];
          sign_d       = req_sign[winner];
          grant_d      = winner;
          last_grant_d = winner;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready[grant_q]) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op1_q        <= 4'd0;
      op2_q        <= 4'd0;
      operation_q  <= 1'b0;
      sign_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= 20'd0;
      done_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      operation_q  <= operation_d;
      sign_q       <= sign_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      done_count_q <= done_count_d;
    end
  end

  assign resp_valid  = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_result = result_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign done_count  = done_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
// Expected values come from an arithmetic ALU model and a round-robin grant model.

module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op1;
  logic [7:0]  req_op2;
  logic [1:0]  req_operation;
  logic [1:0]  req_sign;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [19:0] resp_result;
  logic        grant_id;
  logic        busy;
  logic [15:0] done_count;

  int total;
  int bad;
  int model_count;
  int model_last;

  alu_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .req_operation (req_operation),
    .req_sign      (req_sign),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .grant_id      (grant_id),
    .busy          (busy),
    .done_count    (done_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int alu_ref(input int a, input int b, input int op, input int sg);
    if (op == 0 && sg == 0) return a + b;
    if (op == 0) return (a - b + 1048576) % 1048576;
    if (sg == 0) return a * (2 ** b);
    return a / (2 ** b);
  endfunction

  // One full transaction starting in an IDLE negedge; owner response is held off for 'delay' cycles.
  task automatic do_txn(input logic [1:0] mask, input logic [7:0] op1, input logic [7:0] op2,
                        input logic [1:0] opn, input logic [1:0] sgn, input int delay,
                        output int who);
    int w;
    int expv;
    logic [1:0] onehot;
    if (mask == 2'b11) w = 1 - model_last;
    else w = (mask == 2'b10) ? 1 : 0;
    onehot = (w == 1) ? 2'b10 : 2'b01;
    expv = alu_ref((w == 1) ? int'(op1[7:4]) : int'(op1[3:0]),
                   (w == 1) ? int'(op2[7:4]) : int'(op2[3:0]),
                   int'(opn[w]), int'(sgn[w]));
    req_valid = mask;
    req_op1 = op1;
    req_op2 = op2;
    req_operation = opn;
    req_sign = sgn;
    resp_ready = (delay == 0) ? 2'b11 : ~onehot;
    #1;
    total++;
    if (req_ready !== onehot) begin
      bad++;
      $display("FAIL accept_ready: got %b want %b", req_ready, onehot);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || req_ready !== 2'b00 || resp_valid !== 2'b00) begin
      bad++;
      $display("FAIL exec_state: busy=%b req_ready=%b resp_valid=%b want 1 00 00", busy, req_ready, resp_valid);
    end
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== onehot || resp_result !== 20'(expv) || grant_id !== 1'(w) || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL resp_hold: resp_valid=%b result=%h grant=%b req_ready=%b want %b %h %0d 00",
                 resp_valid, resp_result, grant_id, req_ready, onehot, 20'(expv), w);
      end
      if (c == delay) resp_ready = 2'b11;
    end
    @(negedge clk);
    model_count = (model_count + 1) % 65536;
    model_last = w;
    total++;
    if (done_count !== 16'(model_count) || busy !== 1'b0 || resp_valid !== 2'b00 || resp_result !== 20'(expv)) begin
      bad++;
      $display("FAIL complete: done=%0d busy=%b resp_valid=%b result=%h want %0d 0 00 %h",
               done_count, busy, resp_valid, resp_result, model_count, 20'(expv));
    end
    who = w;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_count = 0;
    model_last = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_result !== 20'd0 ||
        grant_id !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: rr=%b rv=%b res=%h g=%b busy=%b dc=%0d want all zero",
               req_ready, resp_valid, resp_result, grant_id, busy, done_count);
    end
  endtask

  task automatic test_single();
    int who;
    do_txn(2'b01, 8'h03, 8'h05, 2'b00, 2'b00, 0, who);
    req_valid = 2'b00;
    total++;
    if (resp_result !== 20'd8 || done_count !== 16'd1) begin
      bad++;
      $display("FAIL single_add: result=%0d done=%0d want 8 1", resp_result, done_count);
    end
  endtask

  task automatic test_ops();
    logic [3:0] a [4] = '{4'd3, 4'd15, 4'd8, 4'd15};
    logic [3:0] b [4] = '{4'd5, 4'd15, 4'd3, 4'd15};
    logic [1:0] o [4] = '{2'b00, 2'b11, 2'b11, 2'b00};
    logic [1:0] s [4] = '{2'b11, 2'b00, 2'b11, 2'b00};
    int fixed [4] = '{32'hFFFFE, 32'h78000, 1, 30};
    int who;
    for (int i = 0; i < 4; i++) begin
      do_txn(2'b10, {a[i], 4'($urandom)}, {b[i], 4'($urandom)},
             {o[i][1], 1'($urandom)}, {s[i][1], 1'($urandom)}, 0, who);
      total++;
      if (who != 1 || resp_result !== 20'(fixed[i])) begin
        bad++;
        $display("FAIL op_req1_%0d: grant=%0d result=%h want 1 %h", i, who, resp_result, 20'(fixed[i]));
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    int who;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_txn(2'b11, 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 0, who);
      total++;
      if (who != (i % 2)) begin
        bad++;
        $display("FAIL rr_order_%0d: grant=%0d want %0d", i, who, i % 2);
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    int who;
    model_last = 1;
    apply_reset();
    do_txn(2'b11, 8'h52, 8'h31, 2'b00, 2'b00, 5, who);
    do_txn(2'b10, 8'h52, 8'h31, 2'b00, 2'b00, 0, who);
    req_valid = 2'b00;
    total++;
    if (who != 1 || resp_result !== 20'd8) begin
      bad++;
      $display("FAIL backpressure_next: grant=%0d result=%0d want 1 8", who, resp_result);
    end
  endtask

  task automatic test_reset_mid();
    int who;
    req_valid = 2'b01;
    req_op1 = 8'h07;
    req_op2 = 8'h02;
    req_operation = 2'b00;
    req_sign = 2'b00;
    resp_ready = 2'b11;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_result !== 20'd0 ||
        grant_id !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid: rr=%b rv=%b res=%h g=%b busy=%b dc=%0d want all zero",
               req_ready, resp_valid, resp_result, grant_id, busy, done_count);
    end
    rst_n = 1'b1;
    req_valid = 2'b00;
    model_count = 0;
    model_last = 1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 2'b00 || done_count !== 16'd0) begin
        bad++;
        $display("FAIL reset_no_resp: rv=%b dc=%0d want 00 0", resp_valid, done_count);
      end
    end
    do_txn(2'b11, 8'h21, 8'h43, 2'b00, 2'b00, 0, who);
    req_valid = 2'b00;
    total++;
    if (who != 0 || resp_result !== 20'd4) begin
      bad++;
      $display("FAIL reset_then_tie: grant=%0d result=%0d want 0 4", who, resp_result);
    end
  endtask

  task automatic test_wrap();
    int who;
    force dut.done_count_q = 16'hFFFE;
    #1;
    release dut.done_count_q;
    model_count = 16'hFFFE;
    do_txn(2'b01, 8'h11, 8'h11, 2'b00, 2'b00, 0, who);
    do_txn(2'b10, 8'h11, 8'h11, 2'b00, 2'b00, 1, who);
    req_valid = 2'b00;
    total++;
    if (done_count !== 16'h0000) begin
      bad++;
      $display("FAIL count_wrap: done=%h want 0000", done_count);
    end
  endtask

  task automatic test_random();
    int who;
    for (int i = 0; i < 40; i++) begin
      do_txn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
             $urandom_range(0, 3), who);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 2'b00;
        @(negedge clk);
      end
    end
    req_valid = 2'b00;
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_count = 0;
    model_last = 1;
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_op1 = 8'h00;
    req_op2 = 8'h00;
    req_operation = 2'b00;
    req_sign = 2'b00;
    resp_ready = 2'b00;
    @(negedge clk);
    test_reset();
    test_single();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
